uart_rx: RTL
============

// Module: uart_rx
// PURPOSE
//  UART receiver: the downstream stage of the UART transmitter on the BASYS3 link.
//  Oversamples the serial line and rebuilds frames: start, P_data_width data bits LSB first,
//  optional parity (PAR_TYP 0=even, 1=odd), one stop bit.
//  Delivers each word in parallel with a single-cycle valid strobe and error flags.
// PARAMETERS
//  CLK_freq      100_000_000  master clock frequency, Hz
//  BAUD_RATE     9600         line bit rate, bits/s
//  P_data_width  8            data bits per frame (>=2)
//  OVERSAMPLE    16           sample ticks per bit (even, >=8)
//  TICK_DIV      CLK_freq/(BAUD_RATE*OVERSAMPLE)  derived; clocks per sample tick (>=2)
// PORTS
//  CLK         in   1             master clock, all logic on posedge
//  RST         in   1             reset, synchronous, active-high
//  RX_IN       in   1             asynchronous serial line, idles high
//  PAR_EN      in   1             1 = frame carries a parity bit
//  PAR_TYP     in   1             0 = even parity, 1 = odd parity
//  P_DATA      out  P_data_width  last received word, held until next DATA_VALID
//  DATA_VALID  out  1             1-cycle strobe: P_DATA/PAR_ERR updated
//  PAR_ERR     out  1             parity mismatch on the word strobed with DATA_VALID
//  STOP_ERR    out  1             1-cycle strobe: stop bit sampled low (framing error)
//  Busy        out  1             high from confirmed start bit until frame end
// BEHAVIOUR
//  - Reset (RST=1 on posedge CLK): all outputs 0, state IDLE, tick counter 0, sync FFs = 1.
//    Applies mid-frame; partial frame discarded, no strobe issued.
//  - RX_IN passes a 2-FF synchronizer (reset value 1); all decisions use the synced line.
//  - Tick counter: free-running, wraps at TICK_DIV-1; one-clock tick at wrap.
//    Cleared on start-edge detection so sampling aligns to the edge.
//  - Sample counter: 0..OVERSAMPLE-1, advances on each tick.
//  - States:
//    IDLE:   armed only after the line has been seen high for >=1 tick.
//            Falling edge -> START; latch PAR_EN and PAR_TYP for the frame.
//    START:  at sample OVERSAMPLE/2-1, line low -> Busy=1, DATA, sample cnt 0.
//            Line high -> glitch; back to IDLE, no output.
//    DATA:   sample at each count OVERSAMPLE-1 (mid-bit); shift in LSB first.
//            After bit P_data_width-1: PAR_EN ? PARITY : STOP.
//    PARITY: mid-bit sample; expected = ^data XOR PAR_TYP; store mismatch -> STOP.
//    STOP:   mid-bit sample.
//            High: next clock DATA_VALID=1, P_DATA=word, PAR_ERR=mismatch (0 if no parity).
//            Low: next clock STOP_ERR=1, no DATA_VALID, P_DATA unchanged, IDLE re-arms
//            only after line high (break does not retrigger).
//            Both cases: Busy=0 and state IDLE on the same clock as the strobe.
//  - Latency: strobe is 1 clock after the stop-bit mid-sample clock.
//  - Back-to-back frames: a start edge arriving right after the stop mid-sample is accepted.
//  - PAR_EN/PAR_TYP changes mid-frame are ignored until the next start edge.
//  - PAR_ERR holds its value until the next DATA_VALID.
// TESTING (bench params: CLK_freq=1_600_000, BAUD_RATE=10_000, OVERSAMPLE=16 -> 160 clk/bit)
//  1. PAR_EN=0, send 8'hA5 -> one DATA_VALID pulse, P_DATA=8'hA5, PAR_ERR=0, STOP_ERR=0.
//  2. PAR_EN=1, PAR_TYP=0, send 8'h03 parity 0 -> P_DATA=8'h03, PAR_ERR=0.
//     Repeat with parity 1 -> DATA_VALID with PAR_ERR=1.
//  3. PAR_EN=1, PAR_TYP=1, send 8'h01 parity 0 -> PAR_ERR=0;
//     frames 8'h00 and 8'hFF back-to-back -> two strobes, no gap errors.
//  4. Stop bit driven low on 8'h5A -> STOP_ERR pulse, no DATA_VALID, P_DATA keeps prior word.
//     Line low 2000 clk -> no new start until line returns high.
//  5. 40-clk low glitch on idle line -> Busy stays 0, no strobes.
//     Real frame 8'h3C afterwards -> received correctly.
//  6. RST=1 for 1 clk at data bit 4 of 8'hC3 -> outputs 0, IDLE, no strobe.
//     Next frame 8'h81 -> P_DATA=8'h81.

Source files
------------

// File: rtl/uart_rx.sv
// uart_rx -- oversampling UART receiver.
//
// Rebuilds frames of the form: start bit, P_data_width data bits (LSB first),
// optional parity bit, one stop bit. Each good frame is delivered on P_DATA
// with a one-cycle DATA_VALID strobe. A low stop bit gives a one-cycle
// STOP_ERR strobe instead.
//
// Ports:
//   CLK         in   master clock, all logic on posedge
//   RST         in   synchronous active-high reset
//   RX_IN       in   asynchronous serial line, idles high
//   PAR_EN      in   1 = frame carries a parity bit (latched at start edge)
//   PAR_TYP     in   0 = even, 1 = odd parity (latched at start edge)
//   P_DATA      out  last received word, held until the next DATA_VALID
//   DATA_VALID  out  one-cycle strobe, P_DATA/PAR_ERR updated
//   PAR_ERR     out  parity mismatch of the last strobed word
//   STOP_ERR    out  one-cycle strobe, stop bit sampled low
//   Busy        out  high from confirmed start bit until frame end
//   o_dbg_state out  current FSM state encoding
//
// Handshake: DATA_VALID and STOP_ERR are single-cycle strobes with no ready;
// the consumer must capture P_DATA/PAR_ERR on the DATA_VALID cycle or later
// (they hold until the next DATA_VALID).
module uart_rx #(
    parameter int CLK_freq     = 100_000_000,
    parameter int BAUD_RATE    = 9600,
    parameter int P_data_width = 8,
    parameter int OVERSAMPLE   = 16
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    RX_IN,
    input  logic                    PAR_EN,
    input  logic                    PAR_TYP,
    output logic [P_data_width-1:0] P_DATA,
    output logic                    DATA_VALID,
    output logic                    PAR_ERR,
    output logic                    STOP_ERR,
    output logic                    Busy,
    output logic [2:0]              o_dbg_state
);

    localparam int TICK_DIV = CLK_freq / (BAUD_RATE * OVERSAMPLE);
    localparam int TICK_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SAMP_W   = $clog2(OVERSAMPLE);
    localparam int BIT_W    = $clog2(P_data_width);
    localparam int HALF     = OVERSAMPLE / 2;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t r_state;
    state_t w_next_state;

    logic                    r_sync1;
    logic                    r_sync2;
    logic                    r_rx_d;
    logic                    r_armed;
    logic [TICK_W-1:0]       r_tick_cnt;
    logic [SAMP_W-1:0]       r_samp_cnt;
    logic [BIT_W-1:0]        r_bit_cnt;
    logic [P_data_width-1:0] r_shift;
    logic                    r_par_en;
    logic                    r_par_typ;
    logic                    r_par_bad;

    logic w_rx;
    logic w_tick;
    logic w_start_edge;
    logic w_start_pt;
    logic w_bit_pt;

    assign w_rx         = r_sync2;
    assign w_tick       = (r_tick_cnt == TICK_W'(TICK_DIV - 1));
    // A falling edge only counts once the line has been high for a tick, so a
    // break that follows a framing error does not look like a new start bit.
    assign w_start_edge = (r_state == IDLE) && r_armed && r_rx_d && !w_rx;
    assign w_start_pt   = w_tick && (r_samp_cnt == SAMP_W'(HALF - 1));
    assign w_bit_pt     = w_tick && (r_samp_cnt == SAMP_W'(OVERSAMPLE - 1));

    assign Busy        = (r_state == DATA) || (r_state == PARITY) || (r_state == STOP);
    assign o_dbg_state = r_state;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_start_edge) w_next_state = START;
            START:   if (w_start_pt) w_next_state = w_rx ? IDLE : DATA;
            DATA:    if (w_bit_pt && (r_bit_cnt == BIT_W'(P_data_width - 1)))
                         w_next_state = r_par_en ? PARITY : STOP;
            PARITY:  if (w_bit_pt) w_next_state = STOP;
            STOP:    if (w_bit_pt) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_sync1    <= 1'b1;
            r_sync2    <= 1'b1;
            r_rx_d     <= 1'b1;
            r_armed    <= 1'b0;
            r_tick_cnt <= '0;
            r_samp_cnt <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_par_en   <= 1'b0;
            r_par_typ  <= 1'b0;
            r_par_bad  <= 1'b0;
            P_DATA     <= '0;
            DATA_VALID <= 1'b0;
            PAR_ERR    <= 1'b0;
            STOP_ERR   <= 1'b0;
        end else begin
            r_sync1    <= RX_IN;
            r_sync2    <= r_sync1;
            r_rx_d     <= w_rx;
            DATA_VALID <= 1'b0;
            STOP_ERR   <= 1'b0;

            // Restarting the tick phase at the edge puts sample points mid-bit.
            if (w_start_edge || w_tick) begin
                r_tick_cnt <= '0;
            end else begin
                r_tick_cnt <= r_tick_cnt + 1'b1;
            end

            if (w_start_edge) begin
                r_samp_cnt <= '0;
            end else if (w_tick) begin
                if ((r_state == START && w_start_pt) ||
                    (r_samp_cnt == SAMP_W'(OVERSAMPLE - 1))) begin
                    r_samp_cnt <= '0;
                end else begin
                    r_samp_cnt <= r_samp_cnt + 1'b1;
                end
            end

            if (r_state == STOP && w_bit_pt && !w_rx) begin
                r_armed <= 1'b0;
            end else if (w_tick && w_rx) begin
                r_armed <= 1'b1;
            end

            if (w_start_edge) begin
                r_par_en  <= PAR_EN;
                r_par_typ <= PAR_TYP;
                r_bit_cnt <= '0;
                r_par_bad <= 1'b0;
            end

            if (r_state == DATA && w_bit_pt) begin
                r_shift   <= {w_rx, r_shift[P_data_width-1:1]};
                r_bit_cnt <= r_bit_cnt + 1'b1;
            end

            if (r_state == PARITY && w_bit_pt) begin
                r_par_bad <= ((^r_shift) ^ r_par_typ) != w_rx;
            end

            if (r_state == STOP && w_bit_pt) begin
                if (w_rx) begin
                    DATA_VALID <= 1'b1;
                    P_DATA     <= r_shift;
                    PAR_ERR    <= r_par_en & r_par_bad;
                end else begin
                    STOP_ERR   <= 1'b1;
                end
            end
        end
    end

endmodule
